// File: rtl/player_damage_if.sv
// Frame-rate bus between the bullet/player geometry sources and the damage block.
// slave = damage block side; master = the driver of positions and strobes.
interface player_damage_if;
  logic        i_ani_stb;
  logic        i_paused;
  logic [11:0] i_px1, i_px2, i_py1, i_py2;
  logic [11:0] i_bx1, i_bx2, i_by1, i_by2;
  logic        i_firing;
  logic        o_hit;
  logic [3:0]  o_lives;
  logic        o_invuln;
  logic        o_visible;
  logic        o_game_over;

  modport master (
    output i_ani_stb, i_paused, i_px1, i_px2, i_py1, i_py2,
           i_bx1, i_bx2, i_by1, i_by2, i_firing,
    input  o_hit, o_lives, o_invuln, o_visible, o_game_over
  );

  modport slave (
    input  i_ani_stb, i_paused, i_px1, i_px2, i_py1, i_py2,
           i_bx1, i_bx2, i_by1, i_by2, i_firing,
    output o_hit, o_lives, o_invuln, o_visible, o_game_over
  );
endinterface

// File: rtl/player_damage.sv
// Player hit detection: bullet/player box overlap per frame, life counter,
// blinking invulnerability window and sticky game-over. Outputs move one clk after the tick.
module player_damage #(
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int FLASH_PERIOD  = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  player_damage_if.slave bus
);
  localparam int INV_W = $clog2(INVULN_FRAMES + 1);
  localparam int FL_W  = $clog2(FLASH_PERIOD + 1);

  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

  state_t           state_q, state_d;
  logic [3:0]       lives_q, lives_d;
  logic [INV_W-1:0] inv_cnt_q, inv_cnt_d;
  logic [FL_W-1:0]  flash_cnt_q, flash_cnt_d;
  logic             hit_q, hit_d;
  logic             visible_q, visible_d;
  logic             invuln_q, invuln_d;
  logic             game_over_q, game_over_d;

  logic tick;
  logic overlap;
  logic hit_qual;

  always_comb begin
    tick     = bus.i_ani_stb & ~bus.i_paused;
    // Strict compares: boxes that only share an edge are not a hit.
    overlap  = (bus.i_bx1 < bus.i_px2) & (bus.i_bx2 > bus.i_px1) &
               (bus.i_by1 < bus.i_py2) & (bus.i_by2 > bus.i_py1);
    hit_qual = tick & bus.i_firing & overlap & (state_q == ALIVE);

    state_d     = state_q;
    lives_d     = lives_q;
    inv_cnt_d   = inv_cnt_q;
    flash_cnt_d = flash_cnt_q;
    hit_d       = 1'b0;
    visible_d   = visible_q;
    invuln_d    = invuln_q;
    game_over_d = game_over_q;

    case (state_q)
      ALIVE: begin
        if (hit_qual) begin
          hit_d = 1'b1;
          if (lives_q > 4'd1) begin
            lives_d     = lives_q - 4'd1;
            inv_cnt_d   = INV_W'(INVULN_FRAMES);
            flash_cnt_d = '0;
            visible_d   = 1'b0;
            invuln_d    = 1'b1;
            state_d     = INVULN;
          end else begin
            lives_d     = 4'd0;
            visible_d   = 1'b0;
            game_over_d = 1'b1;
            state_d     = DEAD;
          end
        end
      end
      INVULN: begin
        if (tick) begin
          inv_cnt_d = inv_cnt_q - INV_W'(1);
          if (inv_cnt_q == INV_W'(1)) begin
            // Exit tick forces the sprite back on instead of flashing.
            flash_cnt_d = '0;
            visible_d   = 1'b1;
            invuln_d    = 1'b0;
            state_d     = ALIVE;
          end else if (flash_cnt_q == FL_W'(FLASH_PERIOD - 1)) begin
            flash_cnt_d = '0;
            visible_d   = ~visible_q;
          end else begin
            flash_cnt_d = flash_cnt_q + FL_W'(1);
          end
        end
      end
      DEAD: begin
        visible_d   = 1'b0;
        invuln_d    = 1'b0;
        game_over_d = 1'b1;
      end
      default: begin
        state_d = ALIVE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ALIVE;
      lives_q     <= 4'(LIVES);
      inv_cnt_q   <= '0;
      flash_cnt_q <= '0;
      hit_q       <= 1'b0;
      visible_q   <= 1'b1;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      inv_cnt_q   <= inv_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      hit_q       <= hit_d;
      visible_q   <= visible_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.o_hit       = hit_q;
  assign bus.o_lives     = lives_q;
  assign bus.o_invuln    = invuln_q;
  assign bus.o_visible   = visible_q;
  assign bus.o_game_over = game_over_q;
endmodule

// File: tb/tb_player_damage.sv
// Bench for player_damage: queued per-cycle expectations from a frame-level model,
// checked by an independent monitor; directed scenarios then randomized play.
module tb_player_damage;
  localparam int LIVES = 3;
  localparam int INV   = 60;
  localparam int FP    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  player_damage_if bus ();

  player_damage #(.LIVES(LIVES), .INVULN_FRAMES(INV), .FLASH_PERIOD(FP)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    bit hit;
    int lives;
    bit invuln;
    bit visible;
    bit game_over;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  // Model: lives left, dead flag, ticks elapsed inside the window (-1 = outside).
  int m_lives;
  bit m_dead;
  int m_elapsed;

  int px1, px2, py1, py2, bx1, bx2, by1, by2;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_lives   = LIVES;
    m_dead    = 1'b0;
    m_elapsed = -1;
  endfunction

  function automatic exp_t model_step(input bit tick, input bit firing, input bit ov);
    exp_t e;
    e.hit = 1'b0;
    if (tick && !m_dead) begin
      if (m_elapsed >= 0) begin
        m_elapsed++;
        if (m_elapsed == INV) m_elapsed = -1;
      end else if (firing && ov) begin
        e.hit = 1'b1;
        if (m_lives > 1) begin
          m_lives--;
          m_elapsed = 0;
        end else begin
          m_lives = 0;
          m_dead  = 1'b1;
        end
      end
    end
    e.lives     = m_lives;
    e.invuln    = (m_elapsed >= 0);
    e.game_over = m_dead;
    if (m_dead)             e.visible = 1'b0;
    else if (m_elapsed < 0) e.visible = 1'b1;
    else                    e.visible = ((m_elapsed / FP) % 2) == 1;
    return e;
  endfunction

  function automatic void set_geom(input int a, b, c, d, e, f, g, h);
    px1 = a; px2 = b; py1 = c; py2 = d;
    bx1 = e; bx2 = f; by1 = g; by2 = h;
  endfunction

  function automatic void rand_geom();
    px1 = $urandom_range(100, 3000); px2 = px1 + $urandom_range(4, 40);
    py1 = $urandom_range(100, 3000); py2 = py1 + $urandom_range(4, 40);
    bx1 = px1 - 30 + $urandom_range(0, 60); bx2 = bx1 + $urandom_range(1, 30);
    by1 = py1 - 30 + $urandom_range(0, 60); by2 = by1 + $urandom_range(1, 30);
  endfunction

  // One clock of stimulus on a frame-strobe cycle using the held geometry.
  task automatic strobe(input bit paused, input bit firing);
    bit ov;
    @(negedge clk);
    bus.i_ani_stb = 1'b1;
    bus.i_paused  = paused;
    bus.i_firing  = firing;
    bus.i_px1 = 12'(px1); bus.i_px2 = 12'(px2); bus.i_py1 = 12'(py1); bus.i_py2 = 12'(py2);
    bus.i_bx1 = 12'(bx1); bus.i_bx2 = 12'(bx2); bus.i_by1 = 12'(by1); bus.i_by2 = 12'(by2);
    ov = (bx1 < px2) && (bx2 > px1) && (by1 < py2) && (by2 > py1);
    sb_q.push_back(model_step(!paused, firing, ov));
  endtask

  // Non-strobe clock carrying junk, often an overlapping firing bullet.
  task automatic idle();
    @(negedge clk);
    bus.i_ani_stb = 1'b0;
    bus.i_paused  = 1'($urandom_range(0, 1));
    bus.i_firing  = 1'b1;
    bus.i_px1 = 12'd100; bus.i_px2 = 12'd200; bus.i_py1 = 12'd100; bus.i_py2 = 12'd200;
    bus.i_bx1 = 12'($urandom_range(90, 150)); bus.i_bx2 = 12'($urandom_range(150, 210));
    bus.i_by1 = 12'($urandom_range(90, 150)); bus.i_by2 = 12'($urandom_range(150, 210));
    sb_q.push_back(model_step(1'b0, 1'b1, 1'b1));
  endtask

  task automatic frame(input bit paused, input bit firing);
    strobe(paused, firing);
    idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hit"},       int'(bus.o_hit),       0);
    chk({tag, "_lives"},     int'(bus.o_lives),     LIVES);
    chk({tag, "_invuln"},    int'(bus.o_invuln),    0);
    chk({tag, "_visible"},   int'(bus.o_visible),   1);
    chk({tag, "_game_over"}, int'(bus.o_game_over), 0);
  endtask

  // Reset asserted away from the clock edge; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    mon_en        = 1'b0;
    bus.i_ani_stb = 1'b0;
    rst           = 1'b1;
    #1;
    check_reset_outputs(tag);
    sb_q.delete();
    model_reset();
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("hit",       int'(bus.o_hit),       int'(e.hit));
        chk("lives",     int'(bus.o_lives),     e.lives);
        chk("invuln",    int'(bus.o_invuln),    int'(e.invuln));
        chk("visible",   int'(bus.o_visible),   int'(e.visible));
        chk("game_over", int'(bus.o_game_over), int'(e.game_over));
      end
    end
  end

  initial begin : stimulus
    bus.i_ani_stb = 1'b0; bus.i_paused = 1'b0; bus.i_firing = 1'b0;
    bus.i_px1 = '0; bus.i_px2 = '0; bus.i_py1 = '0; bus.i_py2 = '0;
    bus.i_bx1 = '0; bus.i_bx2 = '0; bus.i_by1 = '0; bus.i_by2 = '0;
    model_reset();
    #12;
    check_reset_outputs("por");
    do_reset("rst0");

    // Five quiet ticks, bullet far away.
    set_geom(100, 140, 200, 240, 1000, 1020, 1000, 1020);
    for (int i = 0; i < 5; i++) frame(1'b0, 1'b1);

    // Touching edges on x: not a hit.
    set_geom(100, 140, 200, 240, 140, 160, 210, 230);
    frame(1'b0, 1'b1);
    // Touching edges on y: not a hit.
    set_geom(100, 140, 200, 240, 110, 130, 240, 260);
    frame(1'b0, 1'b1);

    // Single hit, then overlap held across the whole window and one more tick.
    set_geom(100, 140, 200, 240, 110, 130, 210, 230);
    for (int i = 0; i < INV + 2; i++) frame(1'b0, 1'b1);
    // Third hit once the second window has expired: game over.
    for (int i = 0; i < INV + 1; i++) frame(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) frame(1'b0, 1'b1);

    // Pause and firing gating from a fresh start.
    do_reset("rst1");
    for (int i = 0; i < 10; i++) frame(1'b1, 1'b1);
    for (int i = 0; i < 3; i++)  frame(1'b0, 1'b0);
    frame(1'b0, 1'b1);
    for (int i = 0; i < 5; i++)  frame(1'b0, 1'b1);

    // Reset in the middle of the invulnerability window.
    do_reset("rst_mid");

    // Randomized play with occasional resets.
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 3) == 0) rand_geom();
      strobe(($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 1) == 0) idle();
      if ($urandom_range(0, 180) == 0) do_reset("rst_rand");
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
